// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between IFU fetches and LSU accesses.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: LSU over IFU).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU,
    OWN_LSU
  } owner_t;

  state_t state;
  state_t state_nxt;
  owner_t owner;
  logic   grant_lsu;
  logic   grant_ifu;
  logic   resp_fire;

`ifdef MEM_ARB_RR_EN
  // last_grant: 1 = LSU won the previous arbitration, 0 = IFU
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (lsu_req_ready) begin
      last_grant <= 1'b1;
    end else if (ifu_req_ready) begin
      last_grant <= 1'b0;
    end
  end

  always_comb begin
    grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant);
    grant_ifu = ifu_req_valid & ~grant_lsu;
  end
`else
  always_comb begin
    grant_lsu = lsu_req_valid;
    grant_ifu = ifu_req_valid & ~lsu_req_valid;
  end
`endif

  assign resp_fire = (state == WAIT) & mem_resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (lsu_req_ready | ifu_req_ready) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    mem_req_valid = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        lsu_req_ready = ~rst & grant_lsu;
        ifu_req_ready = ~rst & grant_ifu;
      end
      REQ:     mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner          <= OWN_NONE;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      unique case (1'b1)
        lsu_req_ready: begin
          owner     <= OWN_LSU;
          mem_wen   <= lsu_wen;
          mem_addr  <= lsu_addr;
          mem_wdata <= lsu_wdata;
          mem_wmask <= lsu_wmask;
        end
        ifu_req_ready: begin
          owner     <= OWN_IFU;
          mem_wen   <= 1'b0;
          mem_addr  <= ifu_addr;
          mem_wdata <= '0;
          mem_wmask <= '0;
        end
        resp_fire: begin
          owner <= OWN_NONE;
          if (owner == OWN_LSU) begin
            lsu_resp_valid <= 1'b1;
            lsu_rdata      <= mem_wen ? '0 : mem_rdata;
          end else if (owner == OWN_IFU) begin
            ifu_resp_valid <= 1'b1;
            ifu_rdata      <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk),
    .rst(rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the memory side of one transaction starting in REQ:
  // ready now, response one cycle later. Returns in the pulse cycle.
  task automatic serve(input logic [31:0] d);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = d;
    step();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    step();
    step();
    checks++;
    if (ifu_req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ifu_ready got %b exp 0", ifu_req_ready);
    end
    checks++;
    if (lsu_req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_lsu_ready got %b exp 0", lsu_req_ready);
    end
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_wen} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got %b exp 0000",
               {ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_wen});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wmask} !== 72'h0) begin
      errors++;
      $display("FAIL rst_mem_fields got %h %h %h exp 0", mem_addr, mem_wdata, mem_wmask);
    end
    checks++;
    if ({ifu_rdata, lsu_rdata} !== 64'h0) begin
      errors++; $display("FAIL rst_rdata got %h %h exp 0", ifu_rdata, lsu_rdata);
    end
    ifu_req_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_ifu_read();
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL ifu_accept got %b exp 10", {ifu_req_ready, lsu_req_ready});
    end
    step();
    ifu_req_valid = 1'b0;
    checks++;
    if ({mem_req_valid, mem_wen, mem_addr} !== {2'b10, 32'h8000_0000}) begin
      errors++;
      $display("FAIL ifu_mem_req got v=%b w=%b a=%h exp 1 0 80000000",
               mem_req_valid, mem_wen, mem_addr);
    end
    serve(32'h0000_0413);
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0000_0413}) begin
      errors++;
      $display("FAIL ifu_resp got %b %b %h exp 1 0 00000413",
               ifu_resp_valid, lsu_resp_valid, ifu_rdata);
    end
    step();
    checks++;
    if ({ifu_resp_valid, ifu_rdata} !== {1'b0, 32'h0000_0413}) begin
      errors++;
      $display("FAIL ifu_pulse_end got %b %h exp 0 00000413", ifu_resp_valid, ifu_rdata);
    end
  endtask

  task automatic test_lsu_write();
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b1;
    lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 8'h0F;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL lsu_accept got %b exp 01", {ifu_req_ready, lsu_req_ready});
    end
    step();
    lsu_req_valid = 1'b0;
    lsu_addr = 32'h0;
    lsu_wdata = 32'h0;
    lsu_wmask = 8'h0;
    lsu_wen = 1'b0;
    ifu_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !==
          {2'b11, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F}) begin
        errors++;
        $display("FAIL lsu_hold%0d got v=%b w=%b a=%h d=%h m=%h", i,
                 mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
      end
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL busy_ready%0d got %b exp 00", i, {ifu_req_ready, lsu_req_ready});
      end
      step();
    end
    ifu_req_valid = 1'b0;
    serve(32'h1234_5678);
    checks++;
    if ({lsu_resp_valid, ifu_resp_valid, lsu_rdata} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL lsu_wr_ack got %b %b %h exp 1 0 00000000",
               lsu_resp_valid, ifu_resp_valid, lsu_rdata);
    end
    checks++;
    if (ifu_rdata !== 32'h0000_0413) begin
      errors++; $display("FAIL ifu_rdata_hold got %h exp 00000413", ifu_rdata);
    end
    step();
    checks++;
    if (lsu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL lsu_pulse_end got %b exp 0", lsu_resp_valid);
    end
  endtask

  // Previous grants were IFU then LSU, so round-robin favours IFU here.
  task automatic test_priority();
    logic lsu_first;
    lsu_first = ~RR;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b0;
    lsu_addr = 32'h8000_2000;
    #1;
    checks++;
    if ({lsu_req_ready, ifu_req_ready} !== {lsu_first, ~lsu_first}) begin
      errors++;
      $display("FAIL prio_first got lsu=%b ifu=%b exp lsu=%b",
               lsu_req_ready, ifu_req_ready, lsu_first);
    end
    step();
    if (lsu_first) lsu_req_valid = 1'b0;
    else ifu_req_valid = 1'b0;
    checks++;
    if (mem_addr !== (lsu_first ? 32'h8000_2000 : 32'h8000_0100)) begin
      errors++; $display("FAIL prio_addr1 got %h", mem_addr);
    end
    serve(32'hAAAA_0001);
    checks++;
    if ({lsu_resp_valid, ifu_resp_valid} !== {lsu_first, ~lsu_first}) begin
      errors++;
      $display("FAIL prio_resp1 got lsu=%b ifu=%b exp lsu=%b",
               lsu_resp_valid, ifu_resp_valid, lsu_first);
    end
    checks++;
    if ({lsu_req_ready, ifu_req_ready} !== {~lsu_first, lsu_first}) begin
      errors++;
      $display("FAIL prio_second got lsu=%b ifu=%b exp lsu=%b",
               lsu_req_ready, ifu_req_ready, ~lsu_first);
    end
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    checks++;
    if (mem_addr !== (lsu_first ? 32'h8000_0100 : 32'h8000_2000)) begin
      errors++; $display("FAIL prio_addr2 got %h", mem_addr);
    end
    serve(32'hBBBB_0002);
    checks++;
    if ({lsu_resp_valid, ifu_resp_valid} !== {~lsu_first, lsu_first}) begin
      errors++;
      $display("FAIL prio_resp2 got lsu=%b ifu=%b exp lsu=%b",
               lsu_resp_valid, ifu_resp_valid, ~lsu_first);
    end
    checks++;
    if ({lsu_rdata, ifu_rdata} !== (lsu_first ? {32'hAAAA_0001, 32'hBBBB_0002}
                                              : {32'hBBBB_0002, 32'hAAAA_0001})) begin
      errors++; $display("FAIL prio_rdata got lsu=%h ifu=%h", lsu_rdata, ifu_rdata);
    end
    step();
  endtask

  task automatic test_resp_in_idle();
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0;
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_resp got %b exp 000",
               {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
    end
    step();
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_resp2 got %b exp 00", {ifu_resp_valid, lsu_resp_valid});
    end
    ifu_req_valid = 1'b1;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_still got ready=%b exp 1", ifu_req_ready);
    end
    ifu_req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0200;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_wen,
         ifu_req_ready, lsu_req_ready} !== 6'b0) begin
      errors++; $display("FAIL midrst_flags nonzero after reset");
    end
    checks++;
    if ({mem_addr, ifu_rdata, lsu_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL midrst_data got a=%h i=%h l=%h exp 0", mem_addr, ifu_rdata, lsu_rdata);
    end
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hCAFE_0000;
    step();
    mem_resp_valid = 1'b0;
    step();
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL midrst_late got %b %b %h exp 0", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
    end
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0300;
    step();
    ifu_req_valid = 1'b0;
    checks++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0300}) begin
      errors++; $display("FAIL midrst_new got v=%b a=%h", mem_req_valid, mem_addr);
    end
    serve(32'h0000_0513);
    checks++;
    if ({ifu_resp_valid, ifu_rdata} !== {1'b1, 32'h0000_0513}) begin
      errors++; $display("FAIL midrst_resp got %b %h exp 1 00000513", ifu_resp_valid, ifu_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int got;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      a = 32'h8000_0000 + 32'(i) * 4;
      ifu_req_valid = 1'b1;
      ifu_addr = a;
      #1;
      checks++;
      if (ifu_req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready%0d got %b exp 1", i, ifu_req_ready);
      end
      step();
      ifu_req_valid = 1'b0;
      checks++;
      if (mem_addr !== a) begin
        errors++; $display("FAIL b2b_addr%0d got %h exp %h", i, mem_addr, a);
      end
      serve(a ^ 32'hA5A5_0000);
      if (ifu_resp_valid === 1'b1) got++;
      checks++;
      if (ifu_rdata !== (a ^ 32'hA5A5_0000)) begin
        errors++;
        $display("FAIL b2b_data%0d got %h exp %h", i, ifu_rdata, a ^ 32'hA5A5_0000);
      end
    end
    checks++;
    if (got !== 10) begin
      errors++; $display("FAIL b2b_count got %0d exp 10", got);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0;
    ifu_addr = '0;
    lsu_req_valid = 1'b0;
    lsu_wen = 1'b0;
    lsu_addr = '0;
    lsu_wdata = '0;
    lsu_wmask = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_priority();
    test_resp_in_idle();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port (DPI-backed pmem read/write) between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time, latches it, and drives a valid/ready request channel toward memory.
- Waits for the memory response and routes it back to the requester that owns the grant.
- Sits between IFU/LSU and the memory model; replaces direct combinational memory access once multi-cycle memory is introduced.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte-mask width (matches DPI byte mask)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response pulse
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wmask  in  MASK_W  LSU byte mask
- lsu_resp_valid  out  1  LSU response pulse (read data or write ack)
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_wmask  out  MASK_W  byte mask
- mem_resp_valid  in  1  memory response / write ack
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset values: all outputs 0; state IDLE; owner = none.
- States:
  - IDLE: choose a winner among asserted req_valid. Default policy is fixed priority, LSU over IFU. Assert that requester's req_ready combinationally in the same cycle. Latch addr/wdata/wmask/wen; IFU requests latch wen=0, wdata=0, wmask=0. Record owner, go to REQ. If no request, stay in IDLE.
  - REQ: mem_req_valid=1 with latched fields, held stable until mem_req_ready=1. Then go to WAIT.
  - WAIT: on mem_resp_valid=1, register mem_rdata into the owner's rdata and pulse the owner's resp_valid for exactly one cycle (the next cycle). For LSU writes, lsu_rdata=0. Return to IDLE.
- Minimum latency: accept at cycle T; mem_req_valid at T+1; if ready at T+1 and response at T+2, owner resp_valid at T+3.
- Only one outstanding transaction. Both req_ready stay 0 outside IDLE.
- Requesters hold valid and payload until they see req_ready. The payload is sampled only in the accept cycle.
- mem_resp_valid in IDLE or REQ is ignored (dropped, no response generated).
- The non-owner's resp_valid never asserts. rdata of the non-owner holds its last value.
- Back-to-back: a new request may be accepted in the IDLE cycle that coincides with the previous resp_valid pulse.
- Reset mid-transaction: return to IDLE immediately and drop the in-flight transaction. No resp_valid is produced; a later mem_resp_valid is ignored.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register (reset value = IFU) selects the priority. When both requesters assert valid in IDLE, grant the one not granted last. A single requester always wins.
- Undefined: fixed LSU-over-IFU priority; no last_grant register.

Test Plan:
- Reset, then IFU read addr 0x80000000; mem_req_ready=1 immediately, mem_resp_valid one cycle later with rdata 0x00000413 -> ifu_resp_valid pulses 1 cycle with ifu_rdata 0x00000413; mem_wen=0.
- LSU write addr 0x80001000, data 0xDEADBEEF, mask 0x0F -> mem_wen=1 with exact fields held for 3 cycles of mem_req_ready=0; after ack, lsu_resp_valid pulses, lsu_rdata=0.
- IFU and LSU both valid in the same IDLE cycle -> LSU granted first, IFU second (fixed). With MEM_ARB_RR_EN and a prior LSU grant -> IFU granted first.
- mem_resp_valid pulsed while in IDLE -> no resp_valid on either side; state stays IDLE.
- rst asserted while in WAIT -> all outputs 0 next cycle; the subsequent mem_resp_valid is ignored; a new IFU request is then served normally.
- 10 back-to-back IFU reads with single-cycle memory -> each ifu_resp_valid matches its address's data, in order; no request dropped.
